// File: rtl/io_timer_pkg.sv
// Shared register map and bit positions for the dual interval timer.
package io_timer_pkg;

  localparam logic [3:0] REG_CTRL     = 4'h0;
  localparam logic [3:0] REG_STATUS   = 4'h1;
  localparam logic [3:0] REG_PRESCALE = 4'h2;
  localparam logic [3:0] REG_T0LO     = 4'h4;
  localparam logic [3:0] REG_T0HI     = 4'h5;
  localparam logic [3:0] REG_T1LO     = 4'h6;
  localparam logic [3:0] REG_T1HI     = 4'h7;

  localparam int unsigned CTRL_EN0   = 0;
  localparam int unsigned CTRL_EN1   = 1;
  localparam int unsigned CTRL_CONT0 = 2;
  localparam int unsigned CTRL_CONT1 = 3;
  localparam int unsigned CTRL_IE0   = 4;
  localparam int unsigned CTRL_IE1   = 5;
  localparam int unsigned CTRL_W     = 6;

  localparam int unsigned ST_F0    = 0;
  localparam int unsigned ST_F1    = 1;
  localparam int unsigned STATUS_W = 2;

endpackage

// File: rtl/io_timer_channel.sv
// One down-counting timer channel: reload register, count, underflow and auto-disable pulses.
module io_timer_channel
  import io_timer_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               tick_i,
  input  logic               en_i,
  input  logic               cont_i,
  input  logic               lo_we_i,
  input  logic               hi_we_i,
  input  logic [7:0]         wdata_i,
  output logic [COUNT_W-1:0] count_o,
  output logic               underflow_o,
  output logic               auto_dis_o
);

  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] reload_q, reload_d;
  logic               run;
  logic               zero;

  always_comb begin
    reload_d = reload_q;
    count_d  = count_q;
    // A hi-byte load supersedes the tick entirely for this cycle.
    run         = tick_i & en_i & ~hi_we_i;
    zero        = (count_q == '0);
    underflow_o = run & zero;
    auto_dis_o  = underflow_o & ~cont_i;
    if (lo_we_i) begin
      reload_d[7:0] = wdata_i;
    end
    if (hi_we_i) begin
      reload_d[COUNT_W-1:8] = wdata_i[COUNT_W-9:0];
      count_d               = reload_d;
    end else if (run) begin
      if (!zero) begin
        count_d = count_q - COUNT_W'(1);
      end else if (cont_i) begin
        count_d = reload_q;
      end else begin
        count_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q  <= '0;
      reload_q <= '0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/io_timer.sv
// Dual interval timer on the 65816 I/O page: bus capture, prescaler, CTRL/STATUS, snapshots, IRQB.
module io_timer
  import io_timer_pkg::*;
#(
  parameter int unsigned COUNT_W = 16,
  parameter int unsigned PRE_W   = 8
) (
  input  logic       SYSCLK,
  input  logic       RESETB,
  input  logic       PHI2,
  input  logic       CSB,
  input  logic       RWB,
  input  logic [3:0] A,
  input  logic [7:0] DB_IN,
  output logic [7:0] DB_OUT,
  output logic       DB_OE,
  output logic       IRQB
);

  logic                phi2_q, armed_q, armed_d;
  logic                cap_csb_q, cap_rwb_q;
  logic [3:0]          cap_a_q;
  logic [7:0]          cap_db_q;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [STATUS_W-1:0] status_q, status_d;
  logic [PRE_W-1:0]    prescale_q, prescale_d, pre_cnt_q, pre_cnt_d;
  logic [COUNT_W-1:0]  snap0_q, snap0_d, snap1_q, snap1_d;
  logic                irqb_q, irqb_d;

  logic               rise, fall, wr, tick;
  logic               we_ctrl, we_status, we_pre, we_t0lo, we_t0hi, we_t1lo, we_t1hi;
  logic [COUNT_W-1:0] count0, count1;
  logic               uf0, uf1, ad0, ad1;

  assign rise = ~phi2_q & PHI2;
  assign fall = phi2_q & ~PHI2;
  assign wr   = fall & armed_q & ~cap_csb_q & ~cap_rwb_q;

  assign we_ctrl   = wr & (cap_a_q == REG_CTRL);
  assign we_status = wr & (cap_a_q == REG_STATUS);
  assign we_pre    = wr & (cap_a_q == REG_PRESCALE);
  assign we_t0lo   = wr & (cap_a_q == REG_T0LO);
  assign we_t0hi   = wr & (cap_a_q == REG_T0HI);
  assign we_t1lo   = wr & (cap_a_q == REG_T1LO);
  assign we_t1hi   = wr & (cap_a_q == REG_T1HI);

  assign tick = (pre_cnt_q == prescale_q);

  io_timer_channel #(.COUNT_W(COUNT_W)) u_ch0 (
    .clk_i       (SYSCLK),
    .rst_ni      (RESETB),
    .tick_i      (tick),
    .en_i        (ctrl_q[CTRL_EN0]),
    .cont_i      (ctrl_q[CTRL_CONT0]),
    .lo_we_i     (we_t0lo),
    .hi_we_i     (we_t0hi),
    .wdata_i     (cap_db_q),
    .count_o     (count0),
    .underflow_o (uf0),
    .auto_dis_o  (ad0)
  );

  io_timer_channel #(.COUNT_W(COUNT_W)) u_ch1 (
    .clk_i       (SYSCLK),
    .rst_ni      (RESETB),
    .tick_i      (tick),
    .en_i        (ctrl_q[CTRL_EN1]),
    .cont_i      (ctrl_q[CTRL_CONT1]),
    .lo_we_i     (we_t1lo),
    .hi_we_i     (we_t1hi),
    .wdata_i     (cap_db_q),
    .count_o     (count1),
    .underflow_o (uf1),
    .auto_dis_o  (ad1)
  );

  always_comb begin
    armed_d    = armed_q;
    ctrl_d     = ctrl_q;
    status_d   = status_q;
    prescale_d = prescale_q;
    pre_cnt_d  = (tick || we_pre) ? '0 : pre_cnt_q + PRE_W'(1);
    snap0_d    = snap0_q;
    snap1_d    = snap1_q;

    if (rise) armed_d = 1'b1;
    if (fall) armed_d = 1'b0;

    if (ad0) ctrl_d[CTRL_EN0] = 1'b0;
    if (ad1) ctrl_d[CTRL_EN1] = 1'b0;
    if (we_ctrl) ctrl_d = cap_db_q[CTRL_W-1:0];

    // Clear first so a same-cycle underflow wins over the W1C.
    if (we_status) status_d = status_q & ~cap_db_q[STATUS_W-1:0];
    if (uf0) status_d[ST_F0] = 1'b1;
    if (uf1) status_d[ST_F1] = 1'b1;

    if (we_pre) prescale_d = cap_db_q[PRE_W-1:0];

    if (rise && !CSB && RWB) begin
      if (A == REG_T0LO) snap0_d = count0;
      if (A == REG_T1LO) snap1_d = count1;
    end

    irqb_d = ~((status_q[ST_F0] & ctrl_q[CTRL_IE0]) | (status_q[ST_F1] & ctrl_q[CTRL_IE1]));
  end

  always_ff @(posedge SYSCLK) begin
    if (!RESETB) begin
      // phi2_q resets high so a bus cycle already in flight at release never looks like a rise.
      phi2_q     <= 1'b1;
      armed_q    <= 1'b0;
      cap_csb_q  <= 1'b1;
      cap_rwb_q  <= 1'b1;
      cap_a_q    <= '0;
      cap_db_q   <= '0;
      ctrl_q     <= '0;
      status_q   <= '0;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      snap0_q    <= '0;
      snap1_q    <= '0;
      irqb_q     <= 1'b1;
    end else begin
      phi2_q     <= PHI2;
      armed_q    <= armed_d;
      if (PHI2) begin
        cap_csb_q <= CSB;
        cap_rwb_q <= RWB;
        cap_a_q   <= A;
        cap_db_q  <= DB_IN;
      end
      ctrl_q     <= ctrl_d;
      status_q   <= status_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      snap0_q    <= snap0_d;
      snap1_q    <= snap1_d;
      irqb_q     <= irqb_d;
    end
  end

  always_comb begin
    DB_OUT = '0;
    unique case (A)
      REG_CTRL:     DB_OUT = {2'b00, ctrl_q};
      REG_STATUS:   DB_OUT = {6'b000000, status_q};
      REG_PRESCALE: DB_OUT = 8'(prescale_q);
      REG_T0LO:     DB_OUT = snap0_q[7:0];
      REG_T0HI:     DB_OUT = snap0_q[COUNT_W-1:8];
      REG_T1LO:     DB_OUT = snap1_q[7:0];
      REG_T1HI:     DB_OUT = snap1_q[COUNT_W-1:8];
      default:      DB_OUT = '0;
    endcase
  end

  assign DB_OE = ~CSB & RWB & PHI2;
  assign IRQB  = irqb_q;

endmodule
